mmio_output_bank: RTL and testbench
===================================

# mmio_output_bank

Parametrised memory-mapped output bank for the multi-cycle MIPS32 data-memory bus, successor to the single 10-bit output port. Provides NCH independently addressable output channels of WIDTH bits. Channel values persist between accesses and support direct/set/clear/toggle write operations, registered read-back and an optional self-clearing timed-pulse mode. The bank sits beside data memory, selected by its own active-low chip enable.

## Interface
- NCH, 4: number of output channels; 1 ≤ NCH ≤ 2^(ADDR_W-3).
- WIDTH, 10: bits per channel; 1 ≤ WIDTH ≤ 32.
- ADDR_W, 5: bus address width seen by the bank.
- PULSE_CYCLES, 1000: pulse duration in clk periods; ≥ 1.
- CNT_W, $clog2(PULSE_CYCLES+1): pulse counter width (derived).
- clk  in  1  system clock; all state updates on the falling edge.
- rst  in  1  synchronous, active-high reset, sampled on the falling edge.
- nce  in  1  chip enable, active low.
- we  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  addr[1:0] = op, addr[ADDR_W-2:2] = channel index, addr[ADDR_W-1] = region (0 = value, 1 = pulse).
- d_in  in  32  write data; only bits [WIDTH-1:0] are used.
- d_out  out  32  registered read data, zero-extended.
- pins  out  NCH*WIDTH  channel k drives pins[k*WIDTH +: WIDTH].

## Operation
- Reset: all channel values 0, all pulse counters 0, pins = 0, d_out = 0.
- Access: occurs when nce = 0 at a falling edge. When nce = 1, channel values hold. This differs from the previous port, which cleared its outputs.
- Channel index ≥ NCH: writes are ignored; reads return 0.
- Value region writes, by op, on channel value V with D = d_in[WIDTH-1:0]:
  - 00: V ← D. Also cancels any active pulse (counter ← 0).
  - 01: V ← V | D.
  - 10: V ← V & ~D.
  - 11: V ← V ^ D.
  - Ops 01/10/11 leave the pulse counter running.
- Pulse region write (any op): V ← D and counter ← PULSE_CYCLES. A write during an active pulse reloads V and restarts the count.
- Pulse countdown:
  - Each falling edge with counter > 0 and no pulse-region write to that channel decrements the counter.
  - On the edge where the counter goes 1 → 0, V ← 0, unless the same edge carries a value-region write to that channel.
  - Same-edge conflict: for op 00 the written value wins and the pulse is cancelled. For ops 01/10/11 the op is applied to 0.
- Reads:
  - Value region: d_out ← zero-extended V.
  - Pulse region: d_out ← zero-extended counter.
  - d_out holds its value while there is no read access.
  - Writes do not change d_out.
- Only one channel can be accessed per edge. Countdowns of other channels proceed independently and in parallel.

## Timing
- Write latency: pins reflect the new value at the same falling edge that samples the access. For a bus phase launched at a rising edge, that is half a cycle.
- Read latency: d_out is valid from the sampling falling edge onward. It is stable for the following rising-edge capture by the CPU.
- Pulse width: V is nonzero for exactly PULSE_CYCLES clk periods after the loading edge, absent intervening writes.
- Reset mid-pulse: counter and value clear on that edge. The pins never glitch to a partial value.
- pins and d_out are direct register outputs with no combinational path from the bus.

## Configuration
- MMIO_OUT_PULSE_EN defined:
  - Pulse counters, pulse-region decode and countdown logic are compiled in, as described above.
- MMIO_OUT_PULSE_EN undefined:
  - No counters are instantiated.
  - Pulse-region writes are ignored; pulse-region reads return 0.
  - Value-region behaviour is unchanged.
  - CNT_W is unused.

## Test plan
- Reset, then read all channels: pins = 0 and every d_out = 0. Then write 0x155 to ch2 with op 00: pins[29:20] = 0x155, other channels 0. Deassert nce for 5 cycles: the value holds.
- Ch0 = 0x0F0, then op 01 with 0x00F → 0x0FF, op 10 with 0x0F0 → 0x00F, op 11 with 0x3FF → 0x3F0. Read back each value via d_out.
- Write to channel index 5 with NCH = 4: no pins change. A read of that index returns d_out = 0.
- With PULSE_CYCLES = 8 and MMIO_OUT_PULSE_EN defined:
  - Pulse-write 0x3FF to ch1. Ch1 stays 0x3FF for 8 periods, then 0.
  - A mid-pulse read of the pulse region returns a decreasing count.
  - A reload at count 3 extends the pulse to 8 more periods.
- Pulse ch3, then op 00 write of 0x001 at count 4: ch3 = 0x001 permanently and its counter reads 0. Separately, op 01 during a pulse: the value is ORed and still clears at expiry.
- Assert rst during an active pulse with ch0 = 0x2AA: the next falling edge gives all pins 0 and counters 0. Rebuilding without MMIO_OUT_PULSE_EN: a pulse-region write has no effect.

Source files
------------

// File: rtl/mmio_output_bank.sv
// mmio_output_bank
//   NCH memory-mapped output channels of WIDTH bits for the data-memory bus.
//   Channel values persist between accesses. Writes can replace, set, clear or
//   toggle bits. Reads are registered. An optional timed-pulse mode loads a
//   value that clears itself after PULSE_CYCLES clock periods.
//
//   All state changes on the falling edge of clk. A bus phase launched on a
//   rising edge is therefore sampled half a cycle later. The read data is then
//   stable for the CPU's next rising-edge capture.
//
//   Build option:
//     MMIO_OUT_PULSE_EN - when defined, compiles in the pulse counters, the
//                         pulse-region decode and the countdown logic. When
//                         undefined, pulse-region writes are ignored and
//                         pulse-region reads return 0.
//
//   Ports:
//     clk    system clock (state updates on the falling edge)
//     rst    synchronous active-high reset, sampled on the falling edge
//     nce    chip enable, active low
//     we     1 = write, 0 = read
//     addr   [1:0] op, [ADDR_W-2:2] channel index,
//            [ADDR_W-1] region (0 = value, 1 = pulse)
//     d_in   write data; only bits [WIDTH-1:0] are used
//     d_out  registered read data, zero-extended
//     pins   channel k drives pins[k*WIDTH +: WIDTH]
module mmio_output_bank #(
    parameter int NCH          = 4,
    parameter int WIDTH        = 10,
    parameter int ADDR_W       = 5,
    parameter int PULSE_CYCLES = 1000,
    parameter int CNT_W        = $clog2(PULSE_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 nce,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [31:0]          d_in,
    output logic [31:0]          d_out,
    output logic [NCH*WIDTH-1:0] pins
);

    localparam int IDX_W = ADDR_W - 3;

    logic             access;
    logic [1:0]       op;
    logic             region;
    logic [IDX_W-1:0] ch_idx;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] chan_val [NCH];
    logic [NCH-1:0]   hit_val;
    logic [31:0]      rd_word;
    logic             unused_din;

`ifdef MMIO_OUT_PULSE_EN
    logic [CNT_W-1:0] pulse_cnt [NCH];
    logic [NCH-1:0]   hit_pls;
`else
    localparam int unused_pulse_cfg = CNT_W + PULSE_CYCLES;
`endif

    // Applies a value-region write op to the current channel value.
    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       o,
                                                  input logic [WIDTH-1:0] v,
                                                  input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        case (o)
            2'b00:   r = d;
            2'b01:   r = v | d;
            2'b10:   r = v & ~d;
            default: r = v ^ d;
        endcase
        return r;
    endfunction

    assign access     = ~nce;
    assign op         = addr[1:0];
    assign region     = addr[ADDR_W-1];
    assign ch_idx     = addr[ADDR_W-2:2];
    assign wdata      = d_in[WIDTH-1:0];
    assign unused_din = ^d_in;

    // Channel decode. An index with no matching channel hits nothing and
    // reads as 0, so out-of-range accesses need no separate check.
    always_comb begin
        hit_val = '0;
`ifdef MMIO_OUT_PULSE_EN
        hit_pls = '0;
`endif
        rd_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_idx == IDX_W'(k)) begin
                hit_val[k] = access & we & ~region;
`ifdef MMIO_OUT_PULSE_EN
                hit_pls[k] = access & we & region;
                rd_word    = region ? 32'(pulse_cnt[k]) : 32'(chan_val[k]);
`else
                rd_word    = region ? 32'd0 : 32'(chan_val[k]);
`endif
            end
        end
    end

    // Channel state, falling-edge stage
    always_ff @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                chan_val[k] <= '0;
`ifdef MMIO_OUT_PULSE_EN
                pulse_cnt[k] <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
`ifdef MMIO_OUT_PULSE_EN
                if (hit_pls[k]) begin
                    // A pulse write (re)loads the value and restarts the count.
                    chan_val[k]  <= wdata;
                    pulse_cnt[k] <= CNT_W'(PULSE_CYCLES);
                end else begin
                    if (pulse_cnt[k] != '0) begin
                        pulse_cnt[k] <= pulse_cnt[k] - CNT_W'(1);
                    end
                    if (hit_val[k]) begin
                        if (op == 2'b00) begin
                            // A direct write wins over expiry and cancels the pulse.
                            chan_val[k]  <= wdata;
                            pulse_cnt[k] <= '0;
                        end else begin
                            // A set/clear/toggle on the expiry edge acts on the cleared value.
                            chan_val[k] <= apply_op(op,
                                                    (pulse_cnt[k] == CNT_W'(1)) ? '0 : chan_val[k],
                                                    wdata);
                        end
                    end else if (pulse_cnt[k] == CNT_W'(1)) begin
                        chan_val[k] <= '0;
                    end
                end
`else
                if (hit_val[k]) begin
                    chan_val[k] <= apply_op(op, chan_val[k], wdata);
                end
`endif
            end
        end
    end

    // Read data, falling-edge stage; holds between reads, unaffected by writes
    always_ff @(negedge clk) begin
        if (rst) begin
            d_out <= '0;
        end else if (access && !we) begin
            d_out <= rd_word;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pins
        assign pins[g*WIDTH +: WIDTH] = chan_val[g];
    end

endmodule

// File: tb/tb_mmio_output_bank.sv
module tb_mmio_output_bank;

    localparam int NCH    = 4;
    localparam int WIDTH  = 10;
    localparam int ADDR_W = 6;
    localparam int PC     = 8;
`ifdef MMIO_OUT_PULSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        nce;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic [39:0] pins;

    int checks   = 0;
    int failures = 0;

    mmio_output_bank #(
        .NCH(NCH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .PULSE_CYCLES(PC)
    ) dut (
        .clk(clk), .rst(rst), .nce(nce), .we(we), .addr(addr),
        .d_in(d_in), .d_out(d_out), .pins(pins)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel keeps a value plus, when a pulse is active, the absolute
    // edge number at which it expires. The visible counter is derived from it.
    logic [9:0]  mval [NCH];
    bit          mact [NCH];
    longint      mexp [NCH];
    logic [31:0] mdout;
    longint      t      = 0;
    bit          mvalid = 1'b0;

    function automatic logic [39:0] mpins();
        logic [39:0] p;
        for (int k = 0; k < NCH; k++) p[k*WIDTH +: WIDTH] = mval[k];
        return p;
    endfunction

    task automatic model_edge();
        int          idx;
        bit          rg;
        logic [1:0]  o;
        logic [9:0]  dv;
        idx = int'(addr[4:2]);
        rg  = addr[5];
        o   = addr[1:0];
        dv  = d_in[9:0];
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                mval[k] = '0; mact[k] = 1'b0; mexp[k] = 0;
            end
            mdout = '0;
        end else begin
            if (!nce && !we) begin
                if (idx >= NCH) mdout = 32'd0;
                else if (rg) mdout = (PEN && mact[idx]) ? 32'(mexp[idx] - (t - 1)) : 32'd0;
                else mdout = 32'(mval[idx]);
            end
            for (int k = 0; k < NCH; k++) begin
                if (mact[k] && mexp[k] == t) begin
                    mval[k] = '0; mact[k] = 1'b0;
                end
            end
            if (!nce && we && idx < NCH) begin
                if (rg) begin
                    if (PEN) begin
                        mval[idx] = dv; mact[idx] = 1'b1; mexp[idx] = t + PC;
                    end
                end else begin
                    case (o)
                        2'b00: begin mval[idx] = dv; mact[idx] = 1'b0; end
                        2'b01: mval[idx] = mval[idx] | dv;
                        2'b10: mval[idx] = mval[idx] & ~dv;
                        default: mval[idx] = mval[idx] ^ dv;
                    endcase
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            t++;
            model_edge();
            mvalid = 1'b1;
        end
    end

    // Compare process: outputs sampled on the rising edge, mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (mvalid) begin
                chk("model_pins", {24'd0, pins}, {24'd0, mpins()});
                chk("model_d_out", {32'd0, d_out}, {32'd0, mdout});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit n, input bit w, input logic [5:0] a,
                         input logic [31:0] d);
        rst = r; nce = n; we = w; addr = a; d_in = d;
        @(negedge clk);
        #1;
        rst = 1'b0; nce = 1'b1; we = 1'b0;
    endtask

    function automatic logic [5:0] ad(input bit rg, input int ch, input logic [1:0] o);
        return {rg, 3'(ch), o};
    endfunction

    task automatic wr(input bit rg, input int ch, input logic [1:0] o, input logic [31:0] d);
        drive(1'b0, 1'b0, 1'b1, ad(rg, ch, o), d);
    endtask

    task automatic rd(input bit rg, input int ch);
        drive(1'b0, 1'b0, 1'b0, ad(rg, ch, 2'b00), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; nce = 1'b1; we = 1'b0; addr = '0; d_in = '0;
        drive(1'b1, 1'b1, 1'b0, 6'd0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 6'd0, 32'd0);
        @(posedge clk);
        chk("reset_pins", {24'd0, pins}, 64'd0);
        chk("reset_d_out", {32'd0, d_out}, 64'd0);
        for (int ch = 0; ch < NCH; ch++) begin
            rd(1'b0, ch);
            @(posedge clk);
            chk("reset_read", {32'd0, d_out}, 64'd0);
        end

        wr(1'b0, 2, 2'b00, 32'h155);
        @(posedge clk);
        chk("ch2_write", {54'd0, pins[29:20]}, 64'h155);
        chk("ch2_pins", {24'd0, pins}, 64'h0015500000);
        idle(5);
        @(posedge clk);
        chk("ch2_hold", {24'd0, pins}, 64'h0015500000);

        wr(1'b0, 0, 2'b00, 32'h0F0); rd(1'b0, 0); @(posedge clk);
        chk("op00_rd", {32'd0, d_out}, 64'h0F0);
        wr(1'b0, 0, 2'b01, 32'h00F); rd(1'b0, 0); @(posedge clk);
        chk("op01_rd", {32'd0, d_out}, 64'h0FF);
        wr(1'b0, 0, 2'b10, 32'h0F0); rd(1'b0, 0); @(posedge clk);
        chk("op10_rd", {32'd0, d_out}, 64'h00F);
        wr(1'b0, 0, 2'b11, 32'hFFFF_F3FF); rd(1'b0, 0); @(posedge clk);
        chk("op11_rd", {32'd0, d_out}, 64'h3F0);

        wr(1'b0, 5, 2'b00, 32'h3FF);
        wr(1'b1, 5, 2'b00, 32'h3FF);
        @(posedge clk);
        chk("oor_pins", {24'd0, pins}, 64'h00155003F0);
        rd(1'b0, 5); @(posedge clk);
        chk("oor_read", {32'd0, d_out}, 64'd0);

`ifdef MMIO_OUT_PULSE_EN
        wr(1'b1, 1, 2'b00, 32'h3FF);
        for (int j = 0; j < PC; j++) begin
            @(posedge clk);
            chk("pulse_high", {54'd0, pins[19:10]}, 64'h3FF);
        end
        @(posedge clk);
        chk("pulse_end", {54'd0, pins[19:10]}, 64'd0);

        wr(1'b1, 1, 2'b00, 32'h155);
        idle(2);
        rd(1'b1, 1); @(posedge clk);
        chk("pulse_cnt_a", {32'd0, d_out}, 64'd6);
        rd(1'b1, 1); @(posedge clk);
        chk("pulse_cnt_b", {32'd0, d_out}, 64'd5);
        idle(1);
        wr(1'b1, 1, 2'b10, 32'h0AA);
        for (int j = 0; j < PC; j++) begin
            @(posedge clk);
            chk("reload_high", {54'd0, pins[19:10]}, 64'h0AA);
        end
        @(posedge clk);
        chk("reload_end", {54'd0, pins[19:10]}, 64'd0);

        wr(1'b1, 3, 2'b00, 32'h3FF);
        idle(4);
        wr(1'b0, 3, 2'b00, 32'h001);
        idle(10);
        @(posedge clk);
        chk("cancel_val", {54'd0, pins[39:30]}, 64'h001);
        rd(1'b1, 3); @(posedge clk);
        chk("cancel_cnt", {32'd0, d_out}, 64'd0);

        wr(1'b1, 2, 2'b00, 32'h100);
        idle(2);
        wr(1'b0, 2, 2'b01, 32'h003);
        @(posedge clk);
        chk("or_in_pulse", {54'd0, pins[29:20]}, 64'h103);
        idle(6);
        @(posedge clk);
        chk("or_expired", {54'd0, pins[29:20]}, 64'd0);

        wr(1'b1, 0, 2'b00, 32'h2AA);
        @(posedge clk);
        chk("rst_pulse_pre", {54'd0, pins[9:0]}, 64'h2AA);
        idle(2);
        drive(1'b1, 1'b1, 1'b0, 6'd0, 32'd0);
        @(posedge clk);
        chk("rst_pulse_pins", {24'd0, pins}, 64'd0);
        rd(1'b1, 0); @(posedge clk);
        chk("rst_pulse_cnt", {32'd0, d_out}, 64'd0);
`else
        wr(1'b1, 1, 2'b00, 32'h3FF);
        @(posedge clk);
        chk("nopulse_pins", {24'd0, pins}, 64'h00155003F0);
        rd(1'b0, 2); @(posedge clk);
        chk("nopulse_rd_val", {32'd0, d_out}, 64'h155);
        rd(1'b1, 1); @(posedge clk);
        chk("nopulse_rd_cnt", {32'd0, d_out}, 64'd0);
`endif

        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 60) == 0, ($urandom % 4) == 0, $urandom % 2,
                  ad($urandom % 2, $urandom_range(0, 5), 2'($urandom % 4)), $urandom);
            if (($urandom % 5) == 0) idle($urandom_range(1, 4));
        end
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
